// File: rtl/div_arbiter_if.sv
// Divider bus between the arbiter (master) and the single shared iterative divider (slave).
interface div_arbiter_if #(
  parameter int BITS = 8
);
  logic            div_start;
  logic [BITS-1:0] div_a;
  logic [BITS-1:0] div_b;
  logic [BITS-1:0] div_q;
  logic [BITS-1:0] div_r;
  logic            div_ready;
  logic            div_err;

  modport master (
    output div_start, div_a, div_b,
    input  div_q, div_r, div_ready, div_err
  );

  modport slave (
    input  div_start, div_a, div_b,
    output div_q, div_r, div_ready, div_err
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one iterative divider between two requesters.
// Operands are latched at grant; results and error flags are held until the next done.
module div_arbiter #(
  parameter int BITS    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      i_req,
  input  logic [BITS-1:0] i_a0,
  input  logic [BITS-1:0] i_b0,
  input  logic [BITS-1:0] i_a1,
  input  logic [BITS-1:0] i_b1,
  output logic [1:0]      o_ack,
  output logic [1:0]      o_done,
  output logic [BITS-1:0] o_res_q,
  output logic [BITS-1:0] o_res_r,
  output logic            o_res_err,
  output logic            o_res_tout,
  output logic            o_busy,
  div_arbiter_if.master   div_bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ZERO  = 3'd4;

  logic [2:0]      r_state;
  logic            r_grant;
  logic            r_rrPtr;
  logic [CW-1:0]   r_wdCount;
  logic [BITS-1:0] r_divA;
  logic [BITS-1:0] r_divB;
  logic [BITS-1:0] r_resQ;
  logic [BITS-1:0] r_resR;
  logic            r_resErr;
  logic            r_resTout;

  logic            w_winner;
  logic [BITS-1:0] w_selA;
  logic [BITS-1:0] w_selB;
  logic [1:0]      w_grantOneHot;
  logic            w_timeout;

  // r_rrPtr names the requester that wins when both ask at once.
  always_comb begin
    w_winner = 1'b0;
    case (i_req)
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = r_rrPtr;
      default: w_winner = 1'b0;
    endcase
  end

  assign w_selA        = w_winner ? i_a1 : i_a0;
  assign w_selB        = w_winner ? i_b1 : i_b0;
  assign w_grantOneHot = r_grant ? 2'b10 : 2'b01;
  assign w_timeout     = (r_wdCount == CW'(TIMEOUT));

  assign o_ack      = (r_state == S_START || r_state == S_ZERO) ? w_grantOneHot : 2'b00;
  assign o_done     = (r_state == S_DONE  || r_state == S_ZERO) ? w_grantOneHot : 2'b00;
  assign o_busy     = (r_state != S_IDLE);
  assign o_res_q    = r_resQ;
  assign o_res_r    = r_resR;
  assign o_res_err  = r_resErr;
  assign o_res_tout = r_resTout;

  assign div_bus.div_start = (r_state == S_START);
  assign div_bus.div_a     = r_divA;
  assign div_bus.div_b     = r_divB;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_rrPtr   <= 1'b0;
      r_wdCount <= '0;
      r_divA    <= '0;
      r_divB    <= '0;
      r_resQ    <= '0;
      r_resR    <= '0;
      r_resErr  <= 1'b0;
      r_resTout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req != 2'b00) begin
            r_grant <= w_winner;
            r_divA  <= w_selA;
            r_divB  <= w_selB;
            // A zero divisor is answered here so the result is ready in the ZERO cycle.
            if (w_selB == '0) begin
              r_state   <= S_ZERO;
              r_resQ    <= '0;
              r_resR    <= w_selA;
              r_resErr  <= 1'b1;
              r_resTout <= 1'b0;
            end else begin
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          r_rrPtr   <= ~r_grant;
          r_wdCount <= CW'(1);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (div_bus.div_ready) begin
            r_resQ    <= div_bus.div_q;
            r_resR    <= div_bus.div_r;
            r_resErr  <= div_bus.div_err;
            r_resTout <= 1'b0;
            r_wdCount <= '0;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            r_resQ    <= '0;
            r_resR    <= '0;
            r_resErr  <= 1'b1;
            r_resTout <= 1'b1;
            r_wdCount <= '0;
            r_state   <= S_DONE;
          end else begin
            r_wdCount <= r_wdCount + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ZERO: begin
          // Moving the pointer here too keeps a zero-divisor requester from starving the other.
          r_rrPtr <= ~r_grant;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a stand-in divider, a timestamp-level transaction model checked every
// cycle, and directed scenarios with literal expectations.
module tb_div_arbiter;

  localparam int BITS    = 8;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] ack, done;
  logic [7:0] resQ, resR;
  logic       resErr, resTout, busy;

  div_arbiter_if #(.BITS(BITS)) divBus ();

  div_arbiter #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req),
    .i_a0      (a0),
    .i_b0      (b0),
    .i_a1      (a1),
    .i_b1      (b1),
    .o_ack     (ack),
    .o_done    (done),
    .o_res_q   (resQ),
    .o_res_r   (resR),
    .o_res_err (resErr),
    .o_res_tout(resTout),
    .o_busy    (busy),
    .div_bus   (divBus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stand-in divider: answers divLatency edges after it sees start, unless told to hang.
  // It ignores rst so a pulse from an aborted transaction can arrive late.
  int         divLatency = 4;
  bit         divNever   = 1'b0;
  logic [7:0] dA, dB;
  int         divCnt   = 0;
  bit         divActive = 1'b0;

  always @(posedge clk) begin
    divBus.div_ready <= 1'b0;
    divBus.div_err   <= 1'b0;
    if (divActive) begin
      if (divCnt <= 1) begin
        divBus.div_ready <= 1'b1;
        divBus.div_q     <= dA / dB;
        divBus.div_r     <= dA % dB;
        divActive        <= 1'b0;
      end else begin
        divCnt <= divCnt - 1;
      end
    end
    if (divBus.div_start && !divNever) begin
      dA        <= divBus.div_a;
      dB        <= divBus.div_b;
      divCnt    <= divLatency;
      divActive <= 1'b1;
    end
  end

  // Transaction model in terms of cycle timestamps: a grant at edge n acks in cycle n, a
  // non-zero transaction ends at the first ready seen from edge n+2 or at n+TIMEOUT+1,
  // and the arbiter accepts again two edges after the done cycle.
  bit         mPending = 1'b0;
  int         mAckAt   = 0;
  int         mFreeAt  = 0;
  bit         mRr      = 1'b0;
  bit         mG       = 1'b0;
  logic [7:0] mA = '0, mB = '0;
  logic [1:0] expAck = '0, expDone = '0;
  logic       expBusy = 1'b0, expStart = 1'b0;
  logic [7:0] expQ = '0, expR = '0;
  logic       expErr = 1'b0, expTout = 1'b0;

  always @(posedge clk) begin
    cyc      = cyc + 1;
    expAck   = 2'b00;
    expDone  = 2'b00;
    expStart = 1'b0;
    if (rst) begin
      mPending = 1'b0;
      mFreeAt  = cyc + 1;
      mRr      = 1'b0;
      expQ     = '0;
      expR     = '0;
      expErr   = 1'b0;
      expTout  = 1'b0;
    end else if (mPending) begin
      if (cyc >= mAckAt + 2 && divBus.div_ready) begin
        expDone  = mG ? 2'b10 : 2'b01;
        expQ     = mA / mB;
        expR     = mA % mB;
        expErr   = 1'b0;
        expTout  = 1'b0;
        mPending = 1'b0;
        mFreeAt  = cyc + 2;
      end else if (cyc == mAckAt + TIMEOUT + 1) begin
        expDone  = mG ? 2'b10 : 2'b01;
        expQ     = '0;
        expR     = '0;
        expErr   = 1'b1;
        expTout  = 1'b1;
        mPending = 1'b0;
        mFreeAt  = cyc + 2;
      end
    end else if (cyc >= mFreeAt && req != 2'b00) begin
      mG     = (req == 2'b11) ? mRr : req[1];
      mA     = mG ? a1 : a0;
      mB     = mG ? b1 : b0;
      expAck = mG ? 2'b10 : 2'b01;
      mRr    = ~mG;
      if (mB == 8'd0) begin
        expDone = expAck;
        expQ    = '0;
        expR    = mA;
        expErr  = 1'b1;
        expTout = 1'b0;
        mFreeAt = cyc + 2;
      end else begin
        mPending = 1'b1;
        mAckAt   = cyc;
        expStart = 1'b1;
      end
    end
    expBusy = mPending || (cyc < mFreeAt - 1);
  end

  bit ackLog[$];
  int lastAckCyc = 0;
  int startCount = 0;
  int doneCount  = 0;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      checkOutput("ack", {30'd0, ack}, {30'd0, expAck});
      checkOutput("done", {30'd0, done}, {30'd0, expDone});
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("div_start", {31'd0, divBus.div_start}, {31'd0, expStart});
      checkOutput("res_q", {24'd0, resQ}, {24'd0, expQ});
      checkOutput("res_r", {24'd0, resR}, {24'd0, expR});
      checkOutput("res_err", {31'd0, resErr}, {31'd0, expErr});
      checkOutput("res_tout", {31'd0, resTout}, {31'd0, expTout});
      if (expStart) begin
        checkOutput("div_a", {24'd0, divBus.div_a}, {24'd0, mA});
        checkOutput("div_b", {24'd0, divBus.div_b}, {24'd0, mB});
      end
      if (ack != 2'b00) begin
        ackLog.push_back(ack[1]);
        lastAckCyc = cyc;
      end
      if (divBus.div_start) startCount++;
      if (done != 2'b00) doneCount++;
    end
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [7:0] x0, y0, x1, y1);
    @(posedge clk);
    #1;
    req = r;
    a0  = x0;
    b0  = y0;
    a1  = x1;
    b1  = y1;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ack", {30'd0, ack}, 32'd0);
    checkOutput("rst_done", {30'd0, done}, 32'd0);
    checkOutput("rst_res_q", {24'd0, resQ}, 32'd0);
    checkOutput("rst_res_r", {24'd0, resR}, 32'd0);
    checkOutput("rst_res_err", {31'd0, resErr}, 32'd0);
  endtask

  int doneCyc = 0;

  task automatic waitDone(input string name, input logic [1:0] mask, input logic [7:0] q, r,
                          input logic err, tout, output int idle);
    int n;
    idle = 0;
    n    = 0;
    do begin
      @(negedge clk);
      if (!busy) idle++;
      n++;
    end while (done == 2'b00 && n < 400);
    doneCyc = cyc;
    checkOutput({name, "_done"}, {30'd0, done}, {30'd0, mask});
    checkOutput({name, "_q"}, {24'd0, resQ}, {24'd0, q});
    checkOutput({name, "_r"}, {24'd0, resR}, {24'd0, r});
    checkOutput({name, "_err"}, {31'd0, resErr}, {31'd0, err});
    checkOutput({name, "_tout"}, {31'd0, resTout}, {31'd0, tout});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    int idle;
    int startsBefore;
    int donesBefore;
    int n;

    applyReset();

    // Single request from the calculator path.
    divLatency = 8;
    applyStimulus(2'b01, 8'd200, 8'd100, 8'd0, 8'd0);
    waitDone("t1", 2'b01, 8'd2, 8'd0, 1'b0, 1'b0, idle);
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // Simultaneous requests straight after reset: requester 0 first.
    applyReset();
    ackLog.delete();
    divLatency = 3;
    applyStimulus(2'b11, 8'd17, 8'd5, 8'd255, 8'd10);
    waitDone("t2a", 2'b01, 8'd3, 8'd2, 1'b0, 1'b0, idle);
    applyStimulus(2'b10, 8'd17, 8'd5, 8'd255, 8'd10);
    waitDone("t2b", 2'b10, 8'd25, 8'd5, 1'b0, 1'b0, idle);
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    checkOutput("t2_ack_count", ackLog.size(), 32'd2);
    checkOutput("t2_first_grant", {31'd0, ackLog[0]}, 32'd0);
    checkOutput("t2_second_grant", {31'd0, ackLog[1]}, 32'd1);

    // Divide by zero never reaches the divider.
    startsBefore = startCount;
    applyStimulus(2'b10, 8'd0, 8'd0, 8'd7, 8'd0);
    waitDone("t3", 2'b10, 8'd0, 8'd7, 1'b1, 1'b0, idle);
    checkOutput("t3_ack_with_done", {30'd0, ack}, 32'd2);
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    checkOutput("t3_no_start", startCount, startsBefore);

    // Divider hangs: watchdog ends the transaction TIMEOUT+1 cycles after ack.
    divNever = 1'b1;
    applyStimulus(2'b01, 8'd50, 8'd7, 8'd0, 8'd0);
    waitDone("t4", 2'b01, 8'd0, 8'd0, 1'b1, 1'b1, idle);
    checkOutput("t4_ack_to_done", doneCyc - lastAckCyc, TIMEOUT + 1);
    divNever   = 1'b0;
    divLatency = 4;
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    applyStimulus(2'b01, 8'd50, 8'd7, 8'd0, 8'd0);
    waitDone("t4b", 2'b01, 8'd7, 8'd1, 1'b0, 1'b0, idle);
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // Reset during WAIT; the divider's late ready must be ignored.
    divLatency = 12;
    applyStimulus(2'b01, 8'd100, 8'd9, 8'd0, 8'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < 20);
    checkOutput("t5_ack", {30'd0, ack}, 32'd1);
    repeat (4) @(posedge clk);
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    donesBefore = doneCount;
    applyReset();
    repeat (15) @(negedge clk);
    checkOutput("t5_no_done", doneCount, donesBefore);
    divLatency = 2;
    applyStimulus(2'b01, 8'd100, 8'd9, 8'd0, 8'd0);
    waitDone("t5b", 2'b01, 8'd11, 8'd1, 1'b0, 1'b0, idle);
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // Both requesting continuously: strict alternation, one idle cycle between transactions.
    applyReset();
    ackLog.delete();
    divLatency = 2;
    applyStimulus(2'b11, 8'd17, 8'd5, 8'd255, 8'd10);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) waitDone("t6_req0", 2'b01, 8'd3, 8'd2, 1'b0, 1'b0, idle);
      else            waitDone("t6_req1", 2'b10, 8'd25, 8'd5, 1'b0, 1'b0, idle);
      if (k > 0) checkOutput("t6_idle_gap", idle, 32'd1);
    end
    applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (4) @(negedge clk);
    checkOutput("t6_grant_count", ackLog.size(), 32'd8);
    for (int i = 0; i < 8 && i < ackLog.size(); i++) begin
      checkOutput("t6_grant_order", {31'd0, ackLog[i]}, i % 2);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
